// File: rtl/ic_req_router.sv
// ic_req_router: routes CPU requests to one of four address regions, one transaction in flight.
// Unmapped addresses are granted locally and answered with an error response.
module ic_req_router #(
    parameter logic [127:0] BASES = 128'h4000_0000_2000_0000_1000_0000_0000_0000,
    parameter logic [127:0] MASKS = 128'hFFFF_0000_FFFF_0000_FFF0_0000_FFFF_0000
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         cpu_req,
    output logic         cpu_gnt,
    input  logic         cpu_wen,
    input  logic [3:0]   cpu_strb,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic         cpu_recv,
    input  logic         cpu_ack,
    output logic         cpu_error,
    output logic [31:0]  cpu_rdata,
    output logic [3:0]   periph_req,
    input  logic [3:0]   periph_gnt,
    output logic         periph_wen,
    output logic [3:0]   periph_strb,
    output logic [31:0]  periph_addr,
    output logic [31:0]  periph_wdata,
    input  logic [3:0]   periph_recv,
    output logic [3:0]   periph_ack,
    input  logic [3:0]   periph_error,
    input  logic [127:0] periph_rdata
);
    typedef enum logic [1:0] {IDLE, OUTST, ERR} state_t;
    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d, dsel;
    logic [3:0] hit;
    logic       miss, outst, err, rsp_done, can_issue;

    // descending scan leaves the lowest matching region in dsel
    always_comb begin
        hit  = '0;
        dsel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            hit[i] = (cpu_addr & MASKS[32*i +: 32]) == BASES[32*i +: 32];
            if (hit[i]) dsel = 2'(i);
        end
    end

    assign miss      = ~|hit;
    assign outst     = state_q == OUTST;
    assign err       = state_q == ERR;
    assign rsp_done  = cpu_ack && ((outst && periph_recv[sel_q]) || err);
    assign can_issue = state_q == IDLE || rsp_done;

    assign periph_req = (cpu_req && can_issue && !miss) ? 4'b1 << dsel : 4'b0;
    assign cpu_gnt    = cpu_req && can_issue && (miss || periph_gnt[dsel]);
    assign cpu_recv   = (outst && periph_recv[sel_q]) || err;
    assign cpu_error  = err || (outst && periph_error[sel_q]);
    assign cpu_rdata  = outst ? periph_rdata[32*sel_q +: 32] : 32'b0;
    assign periph_ack = (cpu_ack && outst) ? 4'b1 << sel_q : 4'b0;

    assign periph_wen   = cpu_wen;
    assign periph_strb  = cpu_strb;
    assign periph_addr  = cpu_addr;
    assign periph_wdata = cpu_wdata;

    assign state_d = cpu_gnt ? (miss ? ERR : OUTST) : rsp_done ? IDLE : state_q;
    assign sel_d   = (cpu_gnt && !miss) ? dsel : sel_q;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end
endmodule
